// File: rtl/bpu_sram_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// bpu_sram_port_ctrl_if
//   Bundles every non-clock signal of bpu_sram_port_ctrl: the lookup read
//   channel, the update write channel, flush/init_done sideband and the
//   RW0 port of the predictor-table SRAM.
//
//   modport slave  : the port controller itself
//   modport master : its environment (predictor-table logic plus the SRAM
//                    macro, which supplies sram_rdata)
// ---------------------------------------------------------------------------
interface bpu_sram_port_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  // sideband
  logic              flush;
  logic              init_done;
  // lookup read channel
  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_idx;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  // update write channel
  logic              w_req_valid;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_idx;
  logic [DATA_W-1:0] w_req_data;
  logic [DATA_W-1:0] w_req_mask;
  // SRAM RW0 port
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en;
  logic              sram_wmode;
  logic [DATA_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  flush, r_req_valid, r_req_idx,
           w_req_valid, w_req_idx, w_req_data, w_req_mask, sram_rdata,
    output init_done, r_req_ready, r_resp_valid, r_resp_data, w_req_ready,
           sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
  );

  modport master (
    output flush, r_req_valid, r_req_idx,
           w_req_valid, w_req_idx, w_req_data, w_req_mask, sram_rdata,
    input  init_done, r_req_ready, r_resp_valid, r_resp_data, w_req_ready,
           sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
  );
endinterface

// File: rtl/bpu_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// bpu_sram_port_ctrl
//   Sequences one single-port, masked-write predictor SRAM between a lookup
//   reader and an update writer. After reset or flush it sweeps INIT_VAL
//   into every entry; afterwards updates are queued in a small in-order
//   write buffer and the port is arbitrated every cycle:
//     buffer full -> drain head, else accepted read, else drain head.
//
//   Ports:
//     clock, reset : clock (also the SRAM clock), async active-high reset
//     bus (slave)  : flush/init_done, read channel, write channel, SRAM RW0
// ---------------------------------------------------------------------------
module bpu_sram_port_ctrl #(
  parameter int              ADDR_W     = 8,
  parameter int              DATA_W     = 16,
  parameter int              DEPTH      = 256,
  parameter int              WBUF_DEPTH = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  bpu_sram_port_ctrl_if.slave  bus
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       init_cnt_q, init_cnt_d;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WBUF_DEPTH-1:0]   valid_q, valid_d;
  logic                    r_resp_valid_q, r_resp_valid_d;

  logic [ADDR_W-1:0]       buf_idx_q  [WBUF_DEPTH];
  logic [DATA_W-1:0]       buf_data_q [WBUF_DEPTH];
  logic [DATA_W-1:0]       buf_mask_q [WBUF_DEPTH];

  logic                    run, full, r_ready, w_ready, rd_fire, wr_fire, drain;
  logic [WBUF_DEPTH-1:0]   hit_vec;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A lookup may not overtake a pending update to the same index.
  genvar gi;
  generate
    for (gi = 0; gi < WBUF_DEPTH; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[gi] && (buf_idx_q[gi] == bus.r_req_idx);
    end
  endgenerate

  always_comb begin
    run     = (state_q == ST_RUN);
    full    = (count_q == CNT_W'(WBUF_DEPTH));
    r_ready = run && !full && !(|hit_vec);
    w_ready = run && !full;
    rd_fire = bus.r_req_valid && r_ready;
    wr_fire = bus.w_req_valid && w_ready;
    // When full r_ready is low, so this covers both the forced drain and
    // the idle-port drain. A flushing cycle never commits a buffered write.
    drain   = run && !bus.flush && (count_q != '0) && !rd_fire;

    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    head_d         = head_q;
    tail_d         = tail_q;
    valid_d        = valid_q;
    r_resp_valid_d = rd_fire;

    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_W'(1);
      if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
    if (wr_fire) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    count_d = count_q + CNT_W'(wr_fire) - CNT_W'(drain);

    if (bus.flush) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      valid_d    = '0;
    end
  end

  // SRAM port: combinational from state, buffer head and the read request.
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = bus.r_req_idx;
    bus.sram_wmask = buf_mask_q[head_q];
    bus.sram_wdata = buf_data_q[head_q];
    if (state_q == ST_INIT) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = init_cnt_q;
      bus.sram_wmask = '1;
      bus.sram_wdata = INIT_VAL;
    end else if (drain) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = buf_idx_q[head_q];
    end else if (rd_fire) begin
      bus.sram_en    = 1'b1;
    end
    // The state already reads INIT during reset; keep the macro quiet.
    if (reset) begin
      bus.sram_en = 1'b0;
    end
  end

  assign bus.init_done    = run;
  assign bus.r_req_ready  = r_ready;
  assign bus.w_req_ready  = w_ready;
  assign bus.r_resp_valid = r_resp_valid_q;
  assign bus.r_resp_data  = bus.sram_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      r_resp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      r_resp_valid_q <= r_resp_valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      buf_idx_q[tail_q]  <= bus.w_req_idx;
      buf_data_q[tail_q] <= bus.w_req_data;
      buf_mask_q[tail_q] <= bus.w_req_mask;
    end
  end

endmodule

// File: tb/tb_bpu_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpu_sram_port_ctrl
//   Drives bpu_sram_port_ctrl against a behavioural masked-write SRAM.
//   A reference copy of the table contents is updated when updates are
//   accepted; each accepted lookup pushes its expected data, which is
//   popped and compared when r_resp_valid appears.
// ---------------------------------------------------------------------------
module tb_bpu_sram_port_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  bpu_sram_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bpu_sram_port_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WBUF_DEPTH(2), .INIT_VAL(16'h0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural SRAM (1-cycle read latency) ---------------
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    rdata_q = 16'($urandom);
  end
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode)
        mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~bus.sram_wmask) |
                              (bus.sram_wdata & bus.sram_wmask);
      else
        rdata_q <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = rdata_q;

  // ---------------- checking ----------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // ---------------- reference model + scoreboard --------------------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_val;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (bus.r_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'd1, 64'd0);
        end else begin
          exp_val = exp_q.pop_front();
          check("sb_rdata", bus.r_resp_data, exp_val);
        end
      end
      // read is ordered before a same-cycle write to the same index
      if (bus.r_req_valid && bus.r_req_ready)
        exp_q.push_back(ref_mem[bus.r_req_idx]);
      if (bus.w_req_valid && bus.w_req_ready)
        ref_mem[bus.w_req_idx] = (ref_mem[bus.w_req_idx] & ~bus.w_req_mask) |
                                 (bus.w_req_data & bus.w_req_mask);
      if (bus.flush)
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic drive_idle();
    bus.flush       = 1'b0;
    bus.r_req_valid = 1'b0;
    bus.w_req_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic rd(input logic [AW-1:0] idx);
    bus.r_req_valid = 1'b1;
    bus.r_req_idx   = idx;
  endtask

  task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] data, input logic [DW-1:0] mask);
    bus.w_req_valid = 1'b1;
    bus.w_req_idx   = idx;
    bus.w_req_data  = data;
    bus.w_req_mask  = mask;
  endtask

  // Called in the drive phase of the first INIT cycle; returns in the drive
  // phase of the first cycle after the sweep.
  task automatic run_init_sweep(input string tag);
    int bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      sample();
      if (bus.sram_en !== 1'b1 || bus.sram_wmode !== 1'b1 || bus.sram_addr !== AW'(k) ||
          bus.sram_wdata !== 16'h0000 || bus.sram_wmask !== 16'hFFFF ||
          bus.init_done !== 1'b0 || bus.r_req_ready !== 1'b0 || bus.w_req_ready !== 1'b0)
        bad++;
      next_cycle();
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  logic [AW-1:0] rb_list [3];
  int            cyc;

  initial begin
    drive_idle();
    bus.r_req_idx  = '0;
    bus.w_req_idx  = '0;
    bus.w_req_data = '0;
    bus.w_req_mask = '0;
    rb_list[0] = 8'h01; rb_list[1] = 8'h02; rb_list[2] = 8'h03;

    // ---- reset state ----
    repeat (3) @(posedge clock);
    sample();
    check("rst_sram_en",      bus.sram_en,      64'd0);
    check("rst_init_done",    bus.init_done,    64'd0);
    check("rst_r_req_ready",  bus.r_req_ready,  64'd0);
    check("rst_w_req_ready",  bus.w_req_ready,  64'd0);
    check("rst_r_resp_valid", bus.r_resp_valid, 64'd0);

    // ---- init sweep, requests offered but must not be accepted ----
    next_cycle();
    reset = 1'b0;
    rd(8'h07);
    wr(8'h09, 16'hDEAD, 16'hFFFF);
    run_init_sweep("init_sweep");
    drive_idle();
    sample();
    check("init_done_at_256", {bus.init_done, bus.r_req_ready, bus.w_req_ready, bus.sram_en}, 64'b1110);

    // ---- read after init ----
    next_cycle(); rd(8'h12);
    sample(); check("rd12_issue", {bus.sram_en, bus.sram_wmode, bus.sram_addr}, {1'b1, 1'b0, 8'h12});
    next_cycle(); drive_idle();
    sample(); check("rd12_resp_valid", bus.r_resp_valid, 64'd1);
    next_cycle();
    sample(); check("rd12_resp_once", bus.r_resp_valid, 64'd0);

    // ---- write then conflicting read ----
    next_cycle(); wr(8'h40, 16'hABCD, 16'h00FF);
    sample(); check("w40_accept", {bus.w_req_ready, bus.sram_en}, 64'b10);
    next_cycle(); bus.w_req_valid = 1'b0; rd(8'h40);
    sample();
    check("w40_rd_blocked", bus.r_req_ready, 64'd0);
    check("w40_drain", {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wmask, bus.sram_wdata},
          {1'b1, 1'b1, 8'h40, 16'h00FF, 16'hABCD});
    next_cycle();
    sample(); check("w40_rd_accept", {bus.r_req_ready, bus.sram_en, bus.sram_wmode}, 64'b110);
    next_cycle(); drive_idle();
    sample(); check("w40_resp", {bus.r_resp_valid, bus.r_resp_data}, {1'b1, 16'h00CD});

    // ---- back-to-back writes vs continuous reads ----
    next_cycle(); rd(8'h80); wr(8'h01, 16'h1111, 16'hFFFF);
    sample(); check("b2b_c0", {bus.r_req_ready, bus.w_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr},
                    {1'b1, 1'b1, 1'b1, 1'b0, 8'h80});
    next_cycle(); wr(8'h02, 16'h2222, 16'hFFFF);
    sample(); check("b2b_c1", {bus.r_req_ready, bus.w_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr},
                    {1'b1, 1'b1, 1'b1, 1'b0, 8'h80});
    next_cycle(); wr(8'h03, 16'h3333, 16'hFFFF);
    sample(); check("b2b_forced_drain",
                    {bus.r_req_ready, bus.w_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wdata},
                    {1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 16'h1111});
    next_cycle(); bus.w_req_valid = 1'b0;
    sample(); check("b2b_read_wins", {bus.r_req_ready, bus.sram_en, bus.sram_wmode, bus.sram_addr},
                    {1'b1, 1'b1, 1'b0, 8'h80});
    next_cycle(); bus.r_req_valid = 1'b0;
    sample(); check("b2b_drain2", {bus.sram_en, bus.sram_wmode, bus.sram_addr, bus.sram_wdata},
                    {1'b1, 1'b1, 8'h02, 16'h2222});
    next_cycle();
    sample(); check("b2b_idle", bus.sram_en, 64'd0);

    // ---- same-cycle read and write of idx 5 ----
    next_cycle(); rd(8'h05); wr(8'h05, 16'hFFFF, 16'hFFFF);
    sample(); check("same5_both_ready", {bus.r_req_ready, bus.w_req_ready, bus.sram_wmode}, 64'b110);
    next_cycle(); drive_idle();
    sample(); check("same5_old", {bus.r_resp_valid, bus.r_resp_data}, {1'b1, 16'h0000});
    next_cycle(); rd(8'h05);
    sample(); check("same5_rd_ready", bus.r_req_ready, 64'd1);
    next_cycle(); drive_idle();
    sample(); check("same5_new", {bus.r_resp_valid, bus.r_resp_data}, {1'b1, 16'hFFFF});

    // ---- read back earlier writes (data checked by scoreboard) ----
    for (int i = 0; i < 3; i++) begin
      next_cycle(); rd(rb_list[i]);
      sample(); check("readback_ready", bus.r_req_ready, 64'd1);
    end
    next_cycle(); drive_idle();

    // ---- flush with two buffered writes ----
    next_cycle(); rd(8'h80); wr(8'h33, 16'h5A5A, 16'hFFFF);
    sample();
    next_cycle(); wr(8'h34, 16'hA5A5, 16'hFFFF);
    sample();
    next_cycle(); drive_idle(); bus.flush = 1'b1;
    sample(); check("flush_no_drain", bus.sram_en, 64'd0);
    next_cycle(); bus.flush = 1'b0;
    run_init_sweep("flush_sweep");
    sample(); check("flush_buf_empty", {bus.init_done, bus.w_req_ready, bus.sram_en}, 64'b110);
    next_cycle(); rd(8'h33);
    next_cycle(); rd(8'h34);
    next_cycle(); drive_idle();

    // ---- reset in the middle of operation ----
    next_cycle(); rd(8'h80); wr(8'h44, 16'h1234, 16'hFFFF);
    sample();
    next_cycle(); wr(8'h45, 16'h4321, 16'hFFFF);
    sample();
    next_cycle(); drive_idle(); reset = 1'b1;
    sample(); check("midrst_quiet", {bus.sram_en, bus.init_done, bus.r_resp_valid}, 64'b000);
    next_cycle(); reset = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      sample();
      if (bus.init_done === 1'b1) break;
      next_cycle();
      cyc++;
    end
    check("midrst_recover_cycles", 64'(cyc), 64'd256);
    check("midrst_buf_lost", {bus.w_req_ready, bus.sram_en}, 64'b10);
    next_cycle(); rd(8'h44);
    next_cycle(); drive_idle();
    next_cycle();
    sample();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bpu_sram_port_ctrl.md
Name: bpu_sram_port_ctrl

Overview:
Controller that sequences one single-port, masked-write predictor SRAM (DEPTH x DATA_W, 1-cycle read latency, one access per cycle) between a lookup read requester and an update write requester. It performs the post-reset/flush zero-init sweep. It buffers updates in a small in-order write queue and arbitrates the port each cycle. It sits between BPU predictor-table logic and the RW0 port of a table SRAM.

Parameters:
ADDR_W, 8, SRAM index width
DATA_W, 16, SRAM word / mask width
DEPTH, 256, entries (2^ADDR_W)
WBUF_DEPTH, 2, write-buffer entries (>=1)
INIT_VAL, 0, value written to every entry during the init sweep

Ports:
clock  in  1  single clock; also drives the SRAM clock
reset  in  1  asynchronous, active-high reset
flush  in  1  restart init sweep, discard write buffer
init_done  out  1  1 when in RUN state
r_req_valid  in  1  lookup request
r_req_ready  out  1  lookup accepted when valid&ready
r_req_idx  in  ADDR_W  lookup index
r_resp_valid  out  1  read data valid, exactly 1 cycle after acceptance
r_resp_data  out  DATA_W  read data
w_req_valid  in  1  update request
w_req_ready  out  1  update accepted into buffer when valid&ready
w_req_idx  in  ADDR_W  update index
w_req_data  in  DATA_W  update data
w_req_mask  in  DATA_W  per-bit write mask (1 = write)
sram_addr  out  ADDR_W  to RW0_addr
sram_en  out  1  to RW0_en
sram_wmode  out  1  to RW0_wmode (1 = write)
sram_wmask  out  DATA_W  to RW0_wmask
sram_wdata  out  DATA_W  to RW0_wdata
sram_rdata  in  DATA_W  from RW0_rdata

Behaviour:
- Reset (async): state=INIT, init_cnt=0, buffer count=0, r_resp_valid=0. init_done=0, r_req_ready=0, w_req_ready=0. sram_en forced 0 while reset is high.
- INIT: every cycle write addr=init_cnt, wmode=1, wmask=all ones, wdata=INIT_VAL, then init_cnt++. After the write at DEPTH-1, go to RUN. init_done rises exactly DEPTH cycles after reset release. No requests accepted in INIT.
- flush (any state): next state INIT, init_cnt=0, buffer emptied (pending writes dropped). flush in INIT restarts the sweep from 0. A read accepted in the cycle before flush still gets its r_resp_valid.
- Write buffer: in-order FIFO of {idx, data, mask}. w_req_ready = RUN && count<WBUF_DEPTH. No coalescing; duplicate indices are queued and drained in order. An entry accepted in cycle t is drainable from cycle t+1.
- Read conflict: hit = any valid buffer entry idx == r_req_idx. r_req_ready = RUN && count<WBUF_DEPTH && !hit.
- A read and a write to the same idx accepted in the same cycle: the read is ordered first and returns the pre-write data.
- Per-cycle port arbitration in RUN, in priority order:
  1. count==WBUF_DEPTH: drain the head entry.
  2. r_req_valid&&r_req_ready: read, with sram_en=1, wmode=0, addr=r_req_idx.
  3. count>0: drain the head entry.
  4. Otherwise: sram_en=0.
- Drain cycle: sram_en=1, wmode=1, addr/wdata/wmask taken from the head entry; the head is popped at the end of the cycle. Enqueue and dequeue in the same cycle leave count unchanged.
- r_resp_valid <= read issued this cycle. r_resp_data = sram_rdata, passed through combinationally. Read latency is 1 cycle, with 1 read issued per cycle.
- The sram_* outputs are combinational from state, buffer head and the read request. When sram_en=0, the address/data/mask values are don't-care.
- Reset asserted mid-operation: buffer contents are lost and the init sweep reruns.

Test Plan:
- Release reset, keep requests idle -> 256 consecutive init writes to addr 0..255, wdata=0, wmask=0xFFFF. init_done=1 at cycle 256, with r_req_ready and w_req_ready =0 before that.
- After init, read idx 0x12 -> r_resp_valid one cycle later with r_resp_data=0x0000.
- Write idx 0x40 data 0xABCD mask 0x00FF at cycle t, read 0x40 offered from t+1 -> r_req_ready=0 at t+1 while the drain happens. The read is accepted at t+2, and the response at t+3 is 0x00CD.
- Two back-to-back writes (idx 1, 2) with continuous reads to idx 0x80:
  - reads win while count<2;
  - when count==2, that cycle performs a forced drain of idx 1 with r_req_ready=0 and w_req_ready=0;
  - the drain order is 1 then 2.
- Same cycle: read idx 5 and write idx 5 (0xFFFF, full mask) -> the read returns the old value 0x0000, and a later read returns 0xFFFF.
- flush with 2 buffered writes -> buffer emptied, init sweep restarts at addr 0, init_done=0 for 256 cycles, and the buffered writes never reach the SRAM.
